// File: rtl/isa_ddr_fetch_if.sv
// Cache/DDR-facing signal bundle of the instruction fetch block.
// slave is the fetch block's view; master is the cache plus DDR controller side.
`timescale 1ns/1ps
interface isa_ddr_fetch_if #(
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int DDR_DATA_WIDTH = 64,
  parameter int ISA_WIDTH      = 30
);
  logic                      ISA_read_req;
  logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr;
  logic [9:0]                isa_read_len;
  logic [ISA_WIDTH-1:0]      instruction_to_cache;
  logic [9:0]                rd_cnt_isa;
  logic                      rd_burst_data_valid;
  logic                      ddr_rd_req;
  logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr;
  logic [9:0]                ddr_rd_len;
  logic                      ddr_rd_ack;
  logic [DDR_DATA_WIDTH-1:0] ddr_rd_data;
  logic                      ddr_rd_data_valid;
  logic                      fetch_busy;
  logic                      fetch_err;

  modport slave (
    input  ISA_read_req, ISA_read_addr, isa_read_len,
    input  ddr_rd_ack, ddr_rd_data, ddr_rd_data_valid,
    output instruction_to_cache, rd_cnt_isa, rd_burst_data_valid,
    output ddr_rd_req, ddr_rd_addr, ddr_rd_len, fetch_busy, fetch_err
  );

  modport master (
    output ISA_read_req, ISA_read_addr, isa_read_len,
    output ddr_rd_ack, ddr_rd_data, ddr_rd_data_valid,
    input  instruction_to_cache, rd_cnt_isa, rd_burst_data_valid,
    input  ddr_rd_req, ddr_rd_addr, ddr_rd_len, fetch_busy, fetch_err
  );
endinterface

// File: rtl/isa_ddr_fetch.sv
// Converts a level-held instruction-load request into one DDR read burst and
// forwards each beat as an ISA word with a running count and valid strobe.
`timescale 1ns/1ps
module isa_ddr_fetch #(
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int DDR_DATA_WIDTH = 64,
  parameter int ISA_WIDTH      = 30,
  parameter int MAX_BURST      = 128,
  parameter int ACK_TIMEOUT    = 1023
) (
  input logic           clk,
  input logic           rst,
  isa_ddr_fetch_if.slave bus
);

  localparam int              TMO_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [9:0]       MAX_LEN  = 10'(MAX_BURST);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_DATA, S_DONE, S_DRAIN} state_e;

  state_e                    state_q;
  logic [9:0]                beat_q;
  logic [TMO_W-1:0]          tmo_q;
  logic                      req_q;
  logic [DDR_ADDR_WIDTH-1:0] addr_q;
  logic [9:0]                len_q;
  logic [ISA_WIDTH-1:0]      data_q;
  logic [9:0]                cnt_q;
  logic                      strobe_q;
  logic                      err_q;

  logic last_beat;
  assign last_beat = bus.ddr_rd_data_valid && ((beat_q + 10'd1) == len_q);

  // NOTE: every register here is written with <= so all updates in one edge
  // see the pre-edge values; blocking assignments would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      tmo_q    <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: defaulting the strobe first makes it a one-cycle pulse on every path.
      strobe_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.ISA_read_req && (bus.isa_read_len != 10'd0)) begin
            addr_q  <= bus.ISA_read_addr;
            len_q   <= (bus.isa_read_len > MAX_LEN) ? MAX_LEN : bus.isa_read_len;
            cnt_q   <= '0;
            beat_q  <= '0;
            tmo_q   <= '0;
            req_q   <= 1'b1;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          // An ack wins over a same-cycle abort: the burst is then owed to us
          // and is absorbed through DATA/DRAIN.
          if (bus.ddr_rd_ack) begin
            req_q   <= 1'b0;
            state_q <= S_DATA;
          end else if (!bus.ISA_read_req) begin
            req_q   <= 1'b0;
            state_q <= S_IDLE;
          end else if (tmo_q == TMO_LAST) begin
            err_q   <= 1'b1;
            req_q   <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_DATA: begin
          if (!bus.ISA_read_req) begin
            if (bus.ddr_rd_data_valid) beat_q <= beat_q + 10'd1;
            state_q <= last_beat ? S_IDLE : S_DRAIN;
          end else if (bus.ddr_rd_data_valid) begin
            data_q   <= bus.ddr_rd_data[ISA_WIDTH-1:0];
            cnt_q    <= cnt_q + 10'd1;
            strobe_q <= 1'b1;
            beat_q   <= beat_q + 10'd1;
            if (last_beat) state_q <= S_DONE;
          end
        end
        S_DRAIN: begin
          if (bus.ddr_rd_data_valid) begin
            beat_q <= beat_q + 10'd1;
            if (last_beat) state_q <= S_IDLE;
          end
        end
        S_DONE: begin
          if (!bus.ISA_read_req) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ddr_rd_req           = req_q;
  assign bus.ddr_rd_addr          = addr_q;
  assign bus.ddr_rd_len           = len_q;
  assign bus.instruction_to_cache = data_q;
  assign bus.rd_cnt_isa           = cnt_q;
  assign bus.rd_burst_data_valid  = strobe_q;
  assign bus.fetch_err            = err_q;
  assign bus.fetch_busy           = (state_q != S_IDLE);

  // Upper beat bits carry no instruction content.
  if (DDR_DATA_WIDTH > ISA_WIDTH) begin : g_hi_bits
    logic unused_hi;
    assign unused_hi = ^bus.ddr_rd_data[DDR_DATA_WIDTH-1:ISA_WIDTH];
  end

endmodule

// File: tb/tb_isa_ddr_fetch.sv
// Directed plus randomized bench for isa_ddr_fetch; expected words and counts
// come from a burst-level model of what the cache should observe.
`timescale 1ns/1ps
module tb_isa_ddr_fetch;
  localparam int AW  = 28;
  localparam int DW  = 64;
  localparam int IW  = 30;
  localparam int MB  = 128;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  isa_ddr_fetch_if #(.DDR_ADDR_WIDTH(AW), .DDR_DATA_WIDTH(DW), .ISA_WIDTH(IW)) bus ();

  isa_ddr_fetch #(
    .DDR_ADDR_WIDTH(AW), .DDR_DATA_WIDTH(DW), .ISA_WIDTH(IW),
    .MAX_BURST(MB), .ACK_TIMEOUT(TMO)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model of what the cache should currently see.
  logic          err_exp;
  logic [9:0]    cnt_exp;
  logic [IW-1:0] data_exp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ISA_read_req      = 1'b0;
    bus.ISA_read_addr     = '0;
    bus.isa_read_len      = '0;
    bus.ddr_rd_ack        = 1'b0;
    bus.ddr_rd_data       = '0;
    bus.ddr_rd_data_valid = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic strobe);
    check({tag, "_strobe"}, bus.rd_burst_data_valid, strobe);
    check({tag, "_cnt"},    bus.rd_cnt_isa, cnt_exp);
    check({tag, "_data"},   bus.instruction_to_cache, data_exp);
    check({tag, "_err"},    bus.fetch_err, err_exp);
  endtask

  // One complete load: request, ack after ack_dly cycles in REQ, then beats.
  // abort_at != 0 drops the request after that many words were delivered.
  task automatic burst(input logic [AW-1:0] addr, input logic [9:0] len,
                       input int ack_dly, input int gap, input bit rnd_gap,
                       input int abort_at, input bit fixed_data);
    int n;
    n = (len > 10'(MB)) ? MB : int'(len);
    bus.ISA_read_addr = addr;
    bus.isa_read_len  = len;
    bus.ISA_read_req  = 1'b1;
    tick();
    cnt_exp = '0;
    check("req_up",  bus.ddr_rd_req, 1);
    check("rd_addr", bus.ddr_rd_addr, addr);
    check("rd_len",  bus.ddr_rd_len, n);
    check("busy_req", bus.fetch_busy, 1);
    check("cnt_clear", bus.rd_cnt_isa, 0);
    for (int i = 1; i < ack_dly; i++) begin
      tick();
      check("req_hold", bus.ddr_rd_req, 1);
    end
    bus.ddr_rd_ack = 1'b1;
    tick();
    bus.ddr_rd_ack = 1'b0;
    check("req_drop", bus.ddr_rd_req, 0);
    for (int b = 0; b < n; b++) begin
      int g;
      logic [DW-1:0] beat;
      g = rnd_gap ? int'($urandom_range(gap, 0)) : gap;
      for (int k = 0; k < g; k++) begin
        tick();
        check_outs("gap", 1'b0);
      end
      if (abort_at != 0 && b == abort_at) begin
        bus.ISA_read_req = 1'b0;
        tick();
        check_outs("abort", 1'b0);
        check("busy_drain", bus.fetch_busy, 1);
      end
      beat = fixed_data ? DW'(64'hA + 64'(b)) : {$urandom, $urandom};
      bus.ddr_rd_data       = beat;
      bus.ddr_rd_data_valid = 1'b1;
      tick();
      bus.ddr_rd_data_valid = 1'b0;
      if (abort_at == 0 || b < abort_at) begin
        cnt_exp  = cnt_exp + 10'd1;
        data_exp = beat[IW-1:0];
        check_outs("beat", 1'b1);
      end else begin
        check_outs("drain", 1'b0);
      end
    end
    if (abort_at != 0) begin
      check("idle_after_drain", bus.fetch_busy, 0);
    end else begin
      tick();
      check_outs("done_hold", 1'b0);
      check("busy_done", bus.fetch_busy, 1);
      bus.ISA_read_req = 1'b0;
      tick();
      check("idle_after_done", bus.fetch_busy, 0);
      check_outs("idle_hold", 1'b0);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no end of run, required $finish before 2ms");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    err_exp = 1'b0; cnt_exp = '0; data_exp = '0;

    // Reset state
    check("rst_req",  bus.ddr_rd_req, 0);
    check("rst_addr", bus.ddr_rd_addr, 0);
    check("rst_len",  bus.ddr_rd_len, 0);
    check("rst_busy", bus.fetch_busy, 0);
    check_outs("rst", 1'b0);

    // Basic 4-word burst, ack after 3 cycles, beats 0xA..0xD
    burst(28'h40, 10'd4, 3, 0, 1'b0, 0, 1'b1);

    // Zero-length request is never accepted; stray beats in IDLE are ignored
    bus.ISA_read_req = 1'b1; bus.isa_read_len = 10'd0;
    bus.ddr_rd_data = {$urandom, $urandom}; bus.ddr_rd_data_valid = 1'b1;
    repeat (3) begin
      tick();
      check("len0_busy", bus.fetch_busy, 0);
      check("len0_req", bus.ddr_rd_req, 0);
      check_outs("len0", 1'b0);
    end
    idle_inputs();
    tick();

    // Gapped beats, clamped length, then randomized bursts
    burst(AW'($urandom), 10'd3, 1, 2, 1'b0, 0, 1'b0);
    burst(AW'($urandom), 10'd200, 2, 0, 1'b0, 0, 1'b0);
    repeat (4)
      burst(AW'($urandom), 10'($urandom_range(20, 1)), int'($urandom_range(5, 1)), 3, 1'b1, 0, 1'b0);

    // Abort after 2 of 8 beats
    burst(AW'($urandom), 10'd8, 2, 0, 1'b0, 2, 1'b0);

    // Request withdrawn while waiting for ack
    bus.ISA_read_addr = AW'($urandom); bus.isa_read_len = 10'd5; bus.ISA_read_req = 1'b1;
    tick();
    cnt_exp = '0;
    check("wd_req", bus.ddr_rd_req, 1);
    bus.ISA_read_req = 1'b0;
    tick();
    check("wd_req_drop", bus.ddr_rd_req, 0);
    check("wd_idle", bus.fetch_busy, 0);
    check_outs("wd", 1'b0);

    // Ack timeout: error after TMO cycles in REQ
    bus.ISA_read_addr = AW'($urandom); bus.isa_read_len = 10'd6; bus.ISA_read_req = 1'b1;
    tick();
    for (int c = 1; c < TMO; c++) begin
      tick();
      check("tmo_wait_req", bus.ddr_rd_req, 1);
      check("tmo_wait_err", bus.fetch_err, 0);
    end
    tick();
    bus.ISA_read_req = 1'b0;
    err_exp = 1'b1;
    check("tmo_err",  bus.fetch_err, 1);
    check("tmo_req",  bus.ddr_rd_req, 0);
    check("tmo_idle", bus.fetch_busy, 0);
    tick();

    // Error stays set across a later good burst
    burst(AW'($urandom), 10'd5, 1, 1, 1'b1, 0, 1'b0);

    // Reset during beat 2 of 4
    bus.ISA_read_addr = AW'($urandom); bus.isa_read_len = 10'd4; bus.ISA_read_req = 1'b1;
    tick();
    bus.ddr_rd_ack = 1'b1;
    tick();
    bus.ddr_rd_ack = 1'b0;
    bus.ddr_rd_data = {$urandom, $urandom}; bus.ddr_rd_data_valid = 1'b1;
    tick();
    cnt_exp = 10'd1; data_exp = bus.ddr_rd_data[IW-1:0];
    check_outs("pre_rst_beat", 1'b1);
    bus.ddr_rd_data = {$urandom, $urandom};
    rst = 1'b1;
    bus.ISA_read_req = 1'b0;
    tick();
    rst = 1'b0;
    err_exp = 1'b0; cnt_exp = '0; data_exp = '0;
    check("mrst_req",  bus.ddr_rd_req, 0);
    check("mrst_addr", bus.ddr_rd_addr, 0);
    check("mrst_len",  bus.ddr_rd_len, 0);
    check("mrst_busy", bus.fetch_busy, 0);
    check_outs("mrst", 1'b0);
    repeat (2) begin
      bus.ddr_rd_data = {$urandom, $urandom};
      tick();
      check_outs("post_rst_beat", 1'b0);
      check("post_rst_busy", bus.fetch_busy, 0);
    end
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
